// File: rtl/dma_bus_ctl.sv
// Memory-to-memory DMA engine with bus request/grant, burst limit and CPU gap.
// Define DMA_FILL_EN to build in fill mode (CTRL b3: write SRC_LO repeatedly, 1 clk/byte).
module dma_bus_ctl #(
    parameter int unsigned BURST = 16,
    parameter int unsigned GAP   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_n,
    input  logic        we_n,
    input  logic [2:0]  rs,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] dma_ab,
    output logic [7:0]  dma_do,
    output logic        dma_we_n,
    input  logic [7:0]  dma_di,
    output logic        irq_n
);
    localparam logic [7:0] BurstMax = 8'(BURST);
    localparam logic [7:0] GapLast  = 8'(GAP - 1);

    typedef enum logic [2:0] {StIdle, StReq, StRd, StRdw, StWr, StHold, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
    logic [7:0]  burst_q, burst_d, gap_q, gap_d, data_q, data_d, dout_q, dout_d;
    logic        src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
    logic        irq_en_q, irq_en_d, done_q, done_d;
    logic        fill_mode, busy, reg_wr, start;

`ifdef DMA_FILL_EN
    logic fill_q, fill_d;
    assign fill_mode = fill_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end
`else
    assign fill_mode = 1'b0;
`endif

    assign busy   = (state_q != StIdle) && (state_q != StDone);
    assign reg_wr = !cs_n && !we_n;
    assign start  = reg_wr && (rs == 3'd6) && din[0] && !busy;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        burst_d   = burst_q;
        gap_d     = gap_q;
        data_d    = data_q;
        src_inc_d = src_inc_q;
        dst_inc_d = dst_inc_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
`ifdef DMA_FILL_EN
        fill_d    = fill_q;
`endif

        if (reg_wr) begin
            case (rs)
                3'd0: if (!busy) src_d[7:0]  = din;
                3'd1: if (!busy) src_d[15:8] = din;
                3'd2: if (!busy) dst_d[7:0]  = din;
                3'd3: if (!busy) dst_d[15:8] = din;
                3'd4: if (!busy) len_d[7:0]  = din;
                3'd5: if (!busy) len_d[15:8] = din;
                3'd6: begin
                    src_inc_d = din[1];
                    dst_inc_d = din[2];
                    irq_en_d  = din[7];
`ifdef DMA_FILL_EN
                    fill_d    = din[3];
`endif
                end
                default: done_d = 1'b0;
            endcase
        end

        // Every bus state only advances while granted, so a dropped grant freezes the engine.
        case (state_q)
            StIdle, StDone: begin
                if (state_q == StDone) state_d = StIdle;
                if (start) begin
                    if (len_q != 16'd0) begin
                        state_d = StReq;
                        done_d  = 1'b0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            StReq: begin
                if (bus_gnt) begin
                    burst_d = 8'd0;
                    state_d = fill_mode ? StWr : StRd;
                end
            end
            StRd: begin
                if (bus_gnt) state_d = StRdw;
            end
            StRdw: begin
                if (bus_gnt) begin
                    data_d  = dma_di;
                    state_d = StWr;
                end
            end
            StWr: begin
                if (bus_gnt) begin
                    if (src_inc_q && !fill_mode) src_d = src_q + 16'd1;
                    if (dst_inc_q) dst_d = dst_q + 16'd1;
                    len_d   = len_q - 16'd1;
                    burst_d = burst_q + 8'd1;
                    if (len_q == 16'd1) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else if (burst_q + 8'd1 == BurstMax) begin
                        state_d = StHold;
                        gap_d   = 8'd0;
                    end else begin
                        state_d = fill_mode ? StWr : StRd;
                    end
                end
            end
            StHold: begin
                if (gap_q == GapLast) state_d = StReq;
                else gap_d = gap_q + 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        dout_d = 8'h00;
        case (rs)
            3'd0: dout_d = src_q[7:0];
            3'd1: dout_d = src_q[15:8];
            3'd2: dout_d = dst_q[7:0];
            3'd3: dout_d = dst_q[15:8];
            3'd4: dout_d = len_q[7:0];
            3'd5: dout_d = len_q[15:8];
            3'd6: dout_d = {irq_en_q, 3'b000, fill_mode, dst_inc_q, src_inc_q, 1'b0};
            default: dout_d = {done_q, 6'b000000, busy};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            src_q     <= 16'h0000;
            dst_q     <= 16'h0000;
            len_q     <= 16'h0000;
            burst_q   <= 8'h00;
            gap_q     <= 8'h00;
            data_q    <= 8'h00;
            dout_q    <= 8'h00;
            src_inc_q <= 1'b0;
            dst_inc_q <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            dout_q    <= dout_d;
            src_inc_q <= src_inc_d;
            dst_inc_q <= dst_inc_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        dma_ab = 16'h0000;
        dma_do = 8'h00;
        case (state_q)
            StRd, StRdw: dma_ab = src_q;
            StWr: begin
                dma_ab = dst_q;
                dma_do = fill_mode ? src_q[7:0] : data_q;
            end
            default: ;
        endcase
    end

    assign bus_req  = state_q inside {StReq, StRd, StRdw, StWr};
    assign dma_we_n = (state_q != StWr);
    assign irq_n    = ~(done_q & irq_en_q);
    assign dout     = dout_q;

endmodule

// File: tb/tb_dma_bus_ctl.sv
// Bench for dma_bus_ctl: register vector table, then directed transfer sequences
// against a synchronous RAM model and a one-cycle-delay bus arbiter.
module tb_dma_bus_ctl;
    logic        clk;
    logic        reset;
    logic        cs_n, we_n;
    logic [2:0]  rs;
    logic [7:0]  din, dout;
    logic        bus_req, bus_gnt;
    logic [15:0] dma_ab;
    logic [7:0]  dma_do, dma_di;
    logic        dma_we_n, irq_n;

    logic gnt_en, gnt_drop;
    int   checks = 0;
    int   errors = 0;

`ifdef DMA_FILL_EN
    localparam logic [7:0] CtrlFillRb = 8'h88;
`else
    localparam logic [7:0] CtrlFillRb = 8'h80;
`endif

    dma_bus_ctl dut (
        .clk      (clk),
        .reset    (reset),
        .cs_n     (cs_n),
        .we_n     (we_n),
        .rs       (rs),
        .din      (din),
        .dout     (dout),
        .bus_req  (bus_req),
        .bus_gnt  (bus_gnt),
        .dma_ab   (dma_ab),
        .dma_do   (dma_do),
        .dma_we_n (dma_we_n),
        .dma_di   (dma_di),
        .irq_n    (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: unwritten locations return a fixed address-derived pattern.
    logic [7:0] mem [0:65535];
    bit         written [0:65535];

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] peek(input logic [15:0] a);
        return written[a] ? mem[a] : pat(a);
    endfunction

    always @(posedge clk) begin
        dma_di <= peek(dma_ab);
        if (!dma_we_n && bus_gnt) begin
            mem[dma_ab]     <= dma_do;
            written[dma_ab] <= 1'b1;
        end
    end

    always @(posedge clk) bus_gnt <= bus_req && gnt_en && !gnt_drop;

    // Bus activity monitor, sampled on the falling edge.
    int unsigned own_cnt = 0, wr_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    int unsigned low_run = 0, wr_run = 0;
    int unsigned gap_log [16];
    int unsigned bytes_log [16];
    logic prev_req = 1'b0, prev_gnt = 1'b0;

    always @(negedge clk) begin
        if (bus_req === 1'b1 && bus_gnt === 1'b1 && prev_gnt === 1'b1) own_cnt++;
        if (dma_we_n === 1'b0 && bus_gnt === 1'b1) begin
            wr_cnt++;
            wr_run++;
        end
        if (bus_req === 1'b1 && prev_req !== 1'b1) begin
            gap_log[rise_cnt % 16] = low_run;
            rise_cnt++;
            low_run = 0;
        end
        if (bus_req !== 1'b1 && prev_req === 1'b1) begin
            bytes_log[fall_cnt % 16] = wr_run;
            fall_cnt++;
            wr_run = 0;
        end
        if (bus_req !== 1'b1) low_run++;
        prev_req = bus_req;
        prev_gnt = bus_gnt;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] r, input logic [7:0] d);
        @(negedge clk);
        cs_n = 1'b0;
        we_n = 1'b0;
        rs   = r;
        din  = d;
        @(negedge clk);
        cs_n = 1'b1;
        we_n = 1'b1;
    endtask

    task automatic reg_read(input logic [2:0] r, output logic [7:0] d);
        rs = r;
        @(negedge clk);
        d = dout;
    endtask

    task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        reg_write(3'd0, s[7:0]);
        reg_write(3'd1, s[15:8]);
        reg_write(3'd2, d[7:0]);
        reg_write(3'd3, d[15:8]);
        reg_write(3'd4, n[7:0]);
        reg_write(3'd5, n[15:8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        rs = 3'd7;
        @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dout[0] == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 16'(ok), 16'd1);
    endtask

    task automatic wait_we(input string name, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dma_we_n == 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 16'(ok), 16'd1);
    endtask

    typedef struct packed {
        logic       wr;
        logic [2:0] wrs;
        logic [7:0] wd;
        logic [2:0] rrs;
        logic [7:0] exp;
        logic       exp_irq_n;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  rd;
        logic [15:0] ab0;
        int unsigned r0, f0, o0, w0;

        vecs[0]  = '{1'b1, 3'd0, 8'h34, 3'd0, 8'h34, 1'b1};
        vecs[1]  = '{1'b1, 3'd1, 8'h12, 3'd1, 8'h12, 1'b1};
        vecs[2]  = '{1'b1, 3'd2, 8'hCD, 3'd2, 8'hCD, 1'b1};
        vecs[3]  = '{1'b1, 3'd3, 8'hAB, 3'd3, 8'hAB, 1'b1};
        vecs[4]  = '{1'b1, 3'd4, 8'h00, 3'd4, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 3'd5, 8'h00, 3'd5, 8'h00, 1'b1};
        vecs[6]  = '{1'b1, 3'd6, 8'h86, 3'd6, 8'h86, 1'b1};
        vecs[7]  = '{1'b1, 3'd6, 8'h89, 3'd7, 8'h80, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 8'h00, 3'd6, CtrlFillRb, 1'b0};
        vecs[9]  = '{1'b1, 3'd7, 8'h00, 3'd7, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 3'd6, 8'h80, 3'd6, 8'h80, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 8'h00, 3'd1, 8'h12, 1'b1};

        reset = 1'b1; cs_n = 1'b1; we_n = 1'b1; rs = 3'd0; din = 8'h00;
        gnt_en = 1'b1; gnt_drop = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_dma_ab", dma_ab, 16'h0000);
        chk("rst_dma_do", dma_do, 8'h00);
        chk("rst_dma_we_n", dma_we_n, 1'b1);
        chk("rst_irq_n", irq_n, 1'b1);
        reset = 1'b0;
        reg_read(3'd7, rd);
        chk("rst_status", rd, 8'h00);

        // Register table; includes a LEN==0 start that must not touch the bus.
        r0 = rise_cnt;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].wrs, vecs[i].wd);
            reg_read(vecs[i].rrs, rd);
            chk($sformatf("vec%0d_dout", i), rd, vecs[i].exp);
            chk($sformatf("vec%0d_irq_n", i), irq_n, vecs[i].exp_irq_n);
        end
        chk("len0_no_req", 16'(rise_cnt - r0), 16'd0);

        // Four-byte copy with irq enabled.
        setup(16'h0100, 16'h0200, 16'd4);
        o0 = own_cnt; w0 = wr_cnt;
        reg_write(3'd6, 8'h87);
        wait_idle("copy4_done", 100);
        for (int i = 0; i < 4; i++)
            chk($sformatf("copy4_mem%0d", i), peek(16'h0200 + 16'(i)), pat(16'h0100 + 16'(i)));
        chk("copy4_owned_cycles", 16'(own_cnt - o0), 16'd12);
        chk("copy4_writes", 16'(wr_cnt - w0), 16'd4);
        reg_read(3'd7, rd);
        chk("copy4_status", rd, 8'h80);
        chk("copy4_irq_n", irq_n, 1'b0);

        // 40 bytes: three tenures of 16/16/8 with GAP-cycle holes.
        setup(16'h1000, 16'h2000, 16'd40);
        r0 = rise_cnt; f0 = fall_cnt;
        reg_write(3'd6, 8'h07);
        wait_idle("burst_done", 400);
        chk("burst_tenures", 16'(rise_cnt - r0), 16'd3);
        chk("burst_bytes0", 16'(bytes_log[(f0 + 0) % 16]), 16'd16);
        chk("burst_bytes1", 16'(bytes_log[(f0 + 1) % 16]), 16'd16);
        chk("burst_bytes2", 16'(bytes_log[(f0 + 2) % 16]), 16'd8);
        chk("burst_gap1", 16'(gap_log[(r0 + 1) % 16]), 16'd4);
        chk("burst_gap2", 16'(gap_log[(r0 + 2) % 16]), 16'd4);
        reg_read(3'd4, rd);
        chk("burst_len_lo", rd, 8'h00);
        reg_read(3'd5, rd);
        chk("burst_len_hi", rd, 8'h00);
        chk("burst_mem_first", peek(16'h2000), pat(16'h1000));
        chk("burst_mem_last", peek(16'h2027), pat(16'h1027));
        chk("burst_irq_n_masked", irq_n, 1'b1);

        // Source address wraps from 0xFFFF to 0x0000.
        setup(16'hFFFE, 16'h0010, 16'd4);
        reg_write(3'd6, 8'h07);
        wait_idle("wrap_done", 100);
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap_mem%0d", i), peek(16'h0010 + 16'(i)), pat(16'hFFFE + 16'(i)));
        reg_read(3'd0, rd);
        chk("wrap_src_lo", rd, 8'h02);
        reg_read(3'd1, rd);
        chk("wrap_src_hi", rd, 8'h00);
        reg_read(3'd2, rd);
        chk("wrap_dst_lo", rd, 8'h14);

        // Grant withdrawn mid-tenure: engine freezes and resumes without loss.
        setup(16'h3000, 16'h3100, 16'd6);
        w0 = wr_cnt;
        reg_write(3'd6, 8'h07);
        wait_we("drop_first_we", 50);
        gnt_drop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ab0 = dma_ab;
        repeat (4) @(negedge clk);
        chk("drop_ab_held", dma_ab, ab0);
        chk("drop_req_held", bus_req, 1'b1);
        gnt_drop = 1'b0;
        wait_idle("drop_done", 100);
        for (int i = 0; i < 6; i++)
            chk($sformatf("drop_mem%0d", i), peek(16'h3100 + 16'(i)), pat(16'h3000 + 16'(i)));
        chk("drop_writes", 16'(wr_cnt - w0), 16'd6);

`ifdef DMA_FILL_EN
        setup(16'h00A5, 16'h0300, 16'd8);
        o0 = own_cnt;
        reg_write(3'd6, 8'h0D);
        wait_idle("fill_done", 100);
        for (int i = 0; i < 8; i++)
            chk($sformatf("fill_mem%0d", i), peek(16'h0300 + 16'(i)), 8'hA5);
        reg_read(3'd2, rd);
        chk("fill_dst_lo", rd, 8'h08);
        reg_read(3'd3, rd);
        chk("fill_dst_hi", rd, 8'h03);
        reg_read(3'd0, rd);
        chk("fill_src_lo", rd, 8'hA5);
        chk("fill_owned_cycles", 16'(own_cnt - o0), 16'd8);
`endif

        // Writes while busy are ignored; reset during WR drops the bus at once.
        gnt_en = 1'b0;
        setup(16'h4000, 16'h5000, 16'd8);
        reg_write(3'd6, 8'h07);
        reg_write(3'd0, 8'h55);
        reg_read(3'd0, rd);
        chk("busy_src_lo_ignored", rd, 8'h00);
        reg_read(3'd7, rd);
        chk("busy_status", rd, 8'h01);
        gnt_en = 1'b1;
        wait_we("rst_reach_wr", 50);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr_bus_req", bus_req, 1'b0);
        chk("rstwr_dma_we_n", dma_we_n, 1'b1);
        chk("rstwr_dma_ab", dma_ab, 16'h0000);
        reset = 1'b0;
        reg_read(3'd7, rd);
        chk("rstwr_status", rd, 8'h00);
        chk("rstwr_irq_n", irq_n, 1'b1);
        reg_read(3'd0, rd);
        chk("rstwr_src_lo", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
